// File: rtl/timer_sched.sv
// timer_sched: round-robin arbiter sharing one PWM timer between two clients.
// Validates the winner's config, programs period/duty/stop, starts the timer, reports done/err.
module timer_sched #(
  parameter int DW   = 16,
  parameter int TO_W = 20
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic [1:0]      i_req,
  input  logic [3*DW-1:0] i_cfg0,
  input  logic [3*DW-1:0] i_cfg1,
  input  logic            i_abort,
  output logic [1:0]      o_gnt,
  output logic [1:0]      o_done,
  output logic [1:0]      o_err,
  output logic            o_busy,
  output logic            o_we,
  output logic [1:0]      o_addr,
  output logic [DW-1:0]   o_wdata,
  output logic            o_start,
  input  logic            i_timer_end
);

  typedef enum logic [3:0] {
    S_IDLE, S_GRANT, S_CHECK, S_WR_P, S_WR_D, S_WR_S, S_START, S_WAIT, S_DONE, S_ERR
  } state_e;

  state_e          state_q, state_d;
  logic            owner_q, owner_d;
  logic            ptr_q, ptr_d;
  logic [DW-1:0]   period_q, duty_q, stop_q;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            win;
  logic            abortable;

  logic [1:0]      gnt_q, gnt_d;
  logic [1:0]      done_q, done_d;
  logic [1:0]      err_q, err_d;
  logic            busy_q, busy_d;
  logic            we_q, we_d;
  logic [1:0]      addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            start_q, start_d;

  // Requester 1 wins when it is the only one asking, or both ask and the pointer favours it.
  assign win = i_req[1] & (~i_req[0] | ptr_q);

  assign abortable = (state_q == S_CHECK) || (state_q == S_WR_P) || (state_q == S_WR_D) ||
                     (state_q == S_WR_S)  || (state_q == S_START) || (state_q == S_WAIT);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (|i_req) begin
          state_d = S_GRANT;
          owner_d = win;
          ptr_d   = ~win;
        end
      end
      S_GRANT: state_d = S_CHECK;
      S_CHECK: begin
        if ((period_q == '0) || (duty_q > period_q)) state_d = S_ERR;
        else                                         state_d = S_WR_P;
      end
      S_WR_P:  state_d = S_WR_D;
      S_WR_D:  state_d = S_WR_S;
      S_WR_S:  state_d = S_START;
      S_START: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (i_timer_end)       state_d = S_DONE;
        else if (cnt_q == '1)  state_d = S_ERR;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort overrides every other exit, including a simultaneous timer end.
    if (abortable && i_abort) state_d = S_ERR;
  end

  // Outputs are decoded from the next state so they line up with the state they describe.
  always_comb begin
    gnt_d   = 2'b00;
    done_d  = 2'b00;
    err_d   = 2'b00;
    busy_d  = (state_d != S_IDLE);
    we_d    = 1'b0;
    addr_d  = 2'd0;
    wdata_d = '0;
    start_d = 1'b0;
    unique case (state_d)
      S_GRANT: gnt_d = owner_d ? 2'b10 : 2'b01;
      S_WR_P: begin
        we_d    = 1'b1;
        addr_d  = 2'd0;
        wdata_d = period_q;
      end
      S_WR_D: begin
        we_d    = 1'b1;
        addr_d  = 2'd1;
        wdata_d = duty_q;
      end
      S_WR_S: begin
        we_d    = 1'b1;
        addr_d  = 2'd2;
        wdata_d = stop_q;
      end
      S_START: start_d = 1'b1;
      S_DONE:  done_d  = owner_d ? 2'b10 : 2'b01;
      S_ERR:   err_d   = owner_d ? 2'b10 : 2'b01;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q  <= S_IDLE;
      owner_q  <= 1'b0;
      ptr_q    <= 1'b0;
      cnt_q    <= '0;
      period_q <= '0;
      duty_q   <= '0;
      stop_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      // Config is sampled while the grant is visible to the requester.
      if (state_q == S_GRANT) begin
        {stop_q, duty_q, period_q} <= owner_q ? i_cfg1 : i_cfg0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      gnt_q   <= 2'b00;
      done_q  <= 2'b00;
      err_q   <= 2'b00;
      busy_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 2'd0;
      wdata_q <= '0;
      start_q <= 1'b0;
    end else begin
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      start_q <= start_d;
    end
  end

  assign o_gnt   = gnt_q;
  assign o_done  = done_q;
  assign o_err   = err_q;
  assign o_busy  = busy_q;
  assign o_we    = we_q;
  assign o_addr  = addr_q;
  assign o_wdata = wdata_q;
  assign o_start = start_q;

endmodule
